instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Streaming RV32I instruction encoder: packs opcode/register/funct/immediate fields into 32-bit words.
//  It is the inverse of the decode path's immediate extraction and control-signal generation.
//  Feeds the test-program loader and self-check harness that write instruction memory.
//  Valid/ready on both sides, one registered stage and a 2-entry output buffer.
// PARAMETERS
//  CNT_W   16  width of the emitted-instruction counter
// PORTS
//  clk         in   1      single clock, all state on rising edge
//  rst         in   1      synchronous reset, active-high
//  in_valid    in   1      request present
//  in_ready    out  1      encoder can accept a request this cycle
//  in_opcode   in   5      opcodes_t; bits [6:2] of the instruction
//  in_f3       in   3      funct3
//  in_alt      in   1      funct7[5], the SUB/SRA select (OP and OPIMM shifts only)
//  in_rd       in   5      destination register
//  in_rs1      in   5      source register 1
//  in_rs2      in   5      source register 2
//  in_imm      in   32     immediate as a signed/full value, not pre-shuffled
//  out_valid   out  1      encoded word present
//  out_ready   in   1      consumer accepts the word
//  out_instr   out  32     encoded instruction
//  out_err     out  1      word is flagged illegal; travels with out_instr
//  out_count   out  CNT_W  number of words handed off (out_valid & out_ready)
// BEHAVIOUR
//  Reset: buffer empty, out_valid=0, out_instr=0, out_err=0, out_count=0, in_ready=1 on the cycle after reset.
//  Handshake: transfer occurs when valid & ready are both high at a rising edge.
//   - out_valid, out_instr and out_err stay stable while out_valid & !out_ready.
//  Latency: a request accepted at edge N is presented at out_instr after edge N (out_valid=1 from cycle N+1).
//  Buffer: 2 entries, FIFO order.
//   - in_ready = (occupancy < 2), derived from registered occupancy.
//   - Push and pop in the same cycle at occupancy 1 keep occupancy at 1.
//   - At occupancy 2, in_ready=0, so no push is possible.
//  Encoding: instr[1:0]=2'b11 and instr[6:2]=in_opcode.
//   - LUI, AUIPC (U): {imm[31:12], rd}.
//   - JAL (J): {imm[20], imm[10:1], imm[11], imm[19:12], rd}.
//   - JALR, LOAD (I): {imm[11:0], rs1, f3, rd}.
//   - OPIMM (I): same as JALR/LOAD, except for f3=001/101 the upper field is {1'b0, alt, 5'b0, imm[4:0]}.
//   - STORE (S): {imm[11:5], rs2, rs1, f3, imm[4:0]}.
//   - BRANCH (B): {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11]}.
//   - OP (R): {1'b0, alt, 5'b0, rs2, rs1, f3, rd}.
//  Illegal opcode (any value outside opcodes_t): out_instr=32'h0000_0013 (NOP) and out_err=1.
//  out_count increments by 1 per output transfer and wraps modulo 2^CNT_W.
//  Reset mid-operation discards every buffered word; no partial transfer is emitted.
// CONFIGURATION
//  INSTR_ENC_RANGE_CHECK_EN defined: out_err=1 (word still encoded from truncated fields) if any check fails.
//   - I/S: imm[31:11] not all equal.
//   - B: imm[31:12] not all equal, or imm[0]=1.
//   - J: imm[31:20] not all equal, or imm[0]=1.
//   - U: imm[11:0] != 0.
//   - OPIMM shift: imm[31:5] != 0.
//  INSTR_ENC_RANGE_CHECK_EN undefined: fields truncate silently; out_err is raised only for an illegal opcode.
// STRUCTURE
//  coreUtils package additions:
//   - struct enc_req_t (opcode, f3, alt, rd, rs1, rs2, imm).
//   - localparam NOP_INSTR = 32'h0000_0013.
//   - Pack functions put_I/S/B/U/J_imm, the inverses of the get_*_imm functions.
//   - Reuse opcodes_t unchanged.
//  Sub-module instr_field_packer: purely combinational; enc_req_t in, {instr, err} out.
//  Top level holds the input register, 2-entry buffer, occupancy and out_count.
// TESTING
//  1. OPIMM f3=0 rd=1 rs1=0 imm=5 -> out_instr=0x00500093, out_err=0, out_count=1.
//  2. OP f3=0 alt=1 rd=3 rs1=1 rs2=2 -> 0x402081B3; BRANCH f3=0 rs1=1 rs2=2 imm=-4 -> 0xFE208EE3.
//  3. LUI rd=5 imm=0x12345000 -> 0x123452B7; opcode 5'b11111 -> 0x00000013 with out_err=1.
//  4. JAL imm=3 -> out_err=1 with the macro defined; out_err=0 with it undefined.
//  5. Hold out_ready=0 and offer 3 back-to-back requests -> 2 accepted, in_ready=0.
//     - Release out_ready -> words emerge in order and the third request is then accepted.
//  6. Assert rst with 2 words buffered -> next cycle out_valid=0, out_count=0, in_ready=1.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared types and field-packing helpers for the RV32I instruction encoder.
// The put_*_imm functions are the inverses of the decoder's get_*_imm extraction.
package instr_encoder_pkg;

  // Opcode field, instruction bits [6:2]
  typedef enum logic [4:0] {
    OPC_LOAD   = 5'b00000,
    OPC_OPIMM  = 5'b00100,
    OPC_AUIPC  = 5'b00101,
    OPC_STORE  = 5'b01000,
    OPC_OP     = 5'b01100,
    OPC_LUI    = 5'b01101,
    OPC_BRANCH = 5'b11000,
    OPC_JALR   = 5'b11001,
    OPC_JAL    = 5'b11011
  } opcodes_t;

  // The opcode is kept as raw bits so that illegal values can still be represented
  typedef struct packed {
    logic [4:0]  opcode;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } enc_req_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } enc_word_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [31:0] put_I_imm(input logic [31:0] imm);
    return {imm[11:0], 20'b0};
  endfunction

  function automatic logic [31:0] put_S_imm(input logic [31:0] imm);
    return {imm[11:5], 13'b0, imm[4:0], 7'b0};
  endfunction

  function automatic logic [31:0] put_B_imm(input logic [31:0] imm);
    return {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
  endfunction

  function automatic logic [31:0] put_U_imm(input logic [31:0] imm);
    return {imm[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] put_J_imm(input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
  endfunction

  // True when imm[31:lsb] are all copies of one bit, i.e. the value sign-extends from bit lsb
  function automatic logic fits_signed(input logic [31:0] imm, input int unsigned lsb);
    logic [31:0] w_hi;
    w_hi = 32'($signed(imm) >>> lsb);
    return (w_hi == '0) || (w_hi == '1);
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational RV32I field packer: one request in, one encoded word plus error flag out.
// Define INSTR_ENC_RANGE_CHECK_EN to flag immediates that do not fit their field.
module instr_field_packer
  import instr_encoder_pkg::*;
(
  input  enc_req_t    i_req,
  output logic [31:0] o_instr,
  output logic        o_err
);

  logic [31:0] w_rd_f;
  logic [31:0] w_rs1_f;
  logic [31:0] w_rs2_f;
  logic        w_is_shift;
  logic        w_illegal;
  logic        w_range_bad;

  assign w_rd_f     = {20'b0, i_req.rd, i_req.opcode, 2'b11};
  assign w_rs1_f    = {12'b0, i_req.rs1, i_req.f3, 12'b0};
  assign w_rs2_f    = {7'b0, i_req.rs2, 20'b0};
  assign w_is_shift = (i_req.f3[1:0] == 2'b01);

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    o_instr   = NOP_INSTR;
    w_illegal = 1'b0;
    case (i_req.opcode)
      OPC_LUI, OPC_AUIPC: o_instr = put_U_imm(i_req.imm) | w_rd_f;
      OPC_JAL:            o_instr = put_J_imm(i_req.imm) | w_rd_f;
      OPC_JALR, OPC_LOAD: o_instr = put_I_imm(i_req.imm) | w_rs1_f | w_rd_f;
      OPC_OPIMM: begin
        if (w_is_shift)
          o_instr = {1'b0, i_req.alt, 5'b0, i_req.imm[4:0], 20'b0} | w_rs1_f | w_rd_f;
        else
          o_instr = put_I_imm(i_req.imm) | w_rs1_f | w_rd_f;
      end
      OPC_STORE:  o_instr = put_S_imm(i_req.imm) | w_rs2_f | w_rs1_f | {25'b0, i_req.opcode, 2'b11};
      OPC_BRANCH: o_instr = put_B_imm(i_req.imm) | w_rs2_f | w_rs1_f | {25'b0, i_req.opcode, 2'b11};
      OPC_OP:     o_instr = {1'b0, i_req.alt, 25'b0, 5'b0} | w_rs2_f | w_rs1_f | w_rd_f;
      default:    w_illegal = 1'b1;
    endcase
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  always_comb begin
    w_range_bad = 1'b0;
    case (i_req.opcode)
      OPC_LUI, OPC_AUIPC: w_range_bad = (i_req.imm[11:0] != 12'b0);
      OPC_JAL:    w_range_bad = !fits_signed(i_req.imm, 20) || i_req.imm[0];
      OPC_BRANCH: w_range_bad = !fits_signed(i_req.imm, 12) || i_req.imm[0];
      OPC_JALR, OPC_LOAD, OPC_STORE: w_range_bad = !fits_signed(i_req.imm, 11);
      OPC_OPIMM: begin
        if (w_is_shift)
          w_range_bad = (i_req.imm[31:5] != 27'b0);
        else
          w_range_bad = !fits_signed(i_req.imm, 11);
      end
      default: w_range_bad = 1'b0;
    endcase
  end
`else
  assign w_range_bad = 1'b0;
`endif

  assign o_err = w_illegal | w_range_bad;

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder: valid/ready request in, encoded word out through a 2-entry FIFO.
// Range checking of immediates is enabled by defining INSTR_ENC_RANGE_CHECK_EN.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_opcode,
  input  logic [2:0]       in_f3,
  input  logic             in_alt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] out_count
);

  enc_req_t   w_req;
  enc_word_t  w_word;
  logic       w_push;
  logic       w_pop;

  enc_word_t        r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_occ;
  logic [CNT_W-1:0] r_count;

  assign w_req = '{opcode: in_opcode, f3: in_f3, alt: in_alt, rd: in_rd,
                   rs1: in_rs1, rs2: in_rs2, imm: in_imm};

  instr_field_packer u_packer (
    .i_req   (w_req),
    .o_instr (w_word.instr),
    .o_err   (w_word.err)
  );

  // The encoded word is captured straight into the buffer, so the buffer is the registered stage
  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the two buffer entries are reset so out_instr/out_err read zero while empty.
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_word;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
        r_count  <= r_count + CNT_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign in_ready  = (r_occ != 2'd2);
  assign out_valid = (r_occ != 2'd0);
  assign out_instr = r_mem[r_rd_ptr].instr;
  assign out_err   = r_mem[r_rd_ptr].err;
  assign out_count = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a queue-based reference model checked every cycle,
// plus directed vectors with hand-encoded words. Honours INSTR_ENC_RANGE_CHECK_EN like the RTL.
`timescale 1ns/1ps
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int CNT_W = 4;
`ifdef INSTR_ENC_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  localparam logic [4:0] LOAD = 5'b00000, OPIMM = 5'b00100, AUIPC = 5'b00101, STORE = 5'b01000,
                         OP = 5'b01100, LUI = 5'b01101, BRANCH = 5'b11000, JALR = 5'b11001,
                         JAL = 5'b11011;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b1;
  enc_req_t         req = '0;
  logic             in_ready;
  logic             out_valid;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] out_count;

  instr_encoder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (req.opcode),
    .in_f3     (req.f3),
    .in_alt    (req.alt),
    .in_rd     (req.rd),
    .in_rs1    (req.rs1),
    .in_rs2    (req.rs2),
    .in_imm    (req.imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  function automatic exp_t model_encode(input enc_req_t r);
    exp_t        e;
    logic [31:0] u;
    longint      s;
    logic [31:0] opc, rdf, rs1f, rs2f;
    bit          bad;
    u    = r.imm;
    s    = longint'($signed(r.imm));
    opc  = (32'(r.opcode) << 2) | 32'd3;
    rdf  = (32'(r.rd) << 7) | opc;
    rs1f = (32'(r.rs1) << 15) | (32'(r.f3) << 12);
    rs2f = 32'(r.rs2) << 20;
    bad  = 1'b0;
    e.err = 1'b0;
    case (r.opcode)
      LUI, AUIPC: begin
        e.instr = (u & 32'hFFFF_F000) | rdf;
        bad = (u % 4096) != 0;
      end
      JAL: begin
        e.instr = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) |
                  (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12) | rdf;
        bad = (s < -1048576) || (s > 1048575) || u[0];
      end
      JALR, LOAD: begin
        e.instr = ((u & 32'hFFF) << 20) | rs1f | rdf;
        bad = (s < -2048) || (s > 2047);
      end
      OPIMM: begin
        if (r.f3 == 3'd1 || r.f3 == 3'd5) begin
          e.instr = (32'(r.alt) << 30) | ((u & 31) << 20) | rs1f | rdf;
          bad = u > 31;
        end else begin
          e.instr = ((u & 32'hFFF) << 20) | rs1f | rdf;
          bad = (s < -2048) || (s > 2047);
        end
      end
      STORE: begin
        e.instr = (((u >> 5) & 127) << 25) | rs2f | rs1f | ((u & 31) << 7) | opc;
        bad = (s < -2048) || (s > 2047);
      end
      BRANCH: begin
        e.instr = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | rs2f | rs1f |
                  (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | opc;
        bad = (s < -4096) || (s > 4095) || u[0];
      end
      OP: e.instr = (32'(r.alt) << 30) | rs2f | rs1f | rdf;
      default: begin
        e.instr = 32'h0000_0013;
        e.err   = 1'b1;
      end
    endcase
    e.err = e.err | (RANGE_EN & bad);
    return e;
  endfunction

  exp_t             mq[$];
  logic [CNT_W-1:0] mcnt = '0;
  bit               live = 1'b0;
  bit               m_push, m_pop;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mcnt = '0;
      live = 1'b1;
    end else begin
      m_push = in_valid && (mq.size() < 2);
      m_pop  = (mq.size() > 0) && out_ready;
      if (m_pop) begin
        void'(mq.pop_front());
        mcnt = mcnt + 1'b1;
      end
      if (m_push) mq.push_back(model_encode(req));
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("out_valid", out_valid, mq.size() != 0);
      check("in_ready", in_ready, mq.size() < 2);
      check("out_count", out_count, mcnt);
      if (mq.size() != 0) begin
        check("out_instr", out_instr, mq[0].instr);
        check("out_err", out_err, mq[0].err);
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic enc_req_t mk(input logic [4:0] op, input logic [2:0] f3, input logic alt,
                                  input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [31:0] imm);
    return '{opcode: op, f3: f3, alt: alt, rd: rd, rs1: rs1, rs2: rs2, imm: imm};
  endfunction

  // Called at a falling edge; returns at the falling edge after the accepting rising edge
  task automatic send(input enc_req_t r);
    bit done;
    done     = 1'b0;
    req      = r;
    in_valid = 1'b1;
    for (int n = 0; n < 64 && !done; n++) begin
      done = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("send_accepted", done, 1'b1);
  endtask

  task automatic send_expect(input string name, input enc_req_t r,
                             input logic [31:0] exp_instr, input logic exp_err);
    send(r);
    check({name, "_instr"}, out_instr, exp_instr);
    check({name, "_err"}, out_err, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_count", out_count, 0);
    check("reset_out_instr", out_instr, 0);
    check("reset_out_err", out_err, 1'b0);

    send_expect("addi", mk(OPIMM, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5), 32'h0050_0093, 1'b0);
    @(negedge clk);
    check("first_count", out_count, 1);

    send_expect("sub", mk(OP, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0), 32'h4020_81B3, 1'b0);
    send_expect("beq", mk(BRANCH, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd4), 32'hFE20_8EE3, 1'b0);
    send_expect("lui", mk(LUI, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000), 32'h1234_52B7, 1'b0);
    send_expect("illegal", mk(5'b11111, 3'd0, 1'b0, 5'd7, 5'd7, 5'd7, 32'hFFFF_FFFF),
                32'h0000_0013, 1'b1);
    send_expect("sw", mk(STORE, 3'd2, 1'b0, 5'd0, 5'd2, 5'd5, 32'd8), 32'h0051_2423, 1'b0);
    send_expect("srai", mk(OPIMM, 3'd5, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3), 32'h4030_D093, 1'b0);
    send_expect("jalr", mk(JALR, 3'd0, 1'b0, 5'd1, 5'd5, 5'd0, 32'hFFFF_FFFF), 32'hFFF2_80E7, 1'b0);
    send_expect("auipc", mk(AUIPC, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'h0000_1000), 32'h0000_1117, 1'b0);
    send_expect("jal_odd", mk(JAL, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd3), 32'h0020_006F, RANGE_EN);
    send_expect("lui_low", mk(LUI, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0000_0123), 32'h0000_0037, RANGE_EN);
    send_expect("addi_2048", mk(OPIMM, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048), 32'h8000_0093, RANGE_EN);
    @(negedge clk);

    // Back-pressure: two words fill the buffer, the third request waits
    out_ready = 1'b0;
    send(mk(OPIMM, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5));
    send(mk(STORE, 3'd2, 1'b0, 5'd0, 5'd2, 5'd5, 32'd8));
    check("full_in_ready", in_ready, 1'b0);
    req      = mk(OP, 3'd6, 1'b0, 5'd4, 5'd3, 5'd2, 32'd0);
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("stall_in_ready", in_ready, 1'b0);
    check("stall_head", out_instr, 32'h0050_0093);
    out_ready = 1'b1;
    send(mk(OP, 3'd6, 1'b0, 5'd4, 5'd3, 5'd2, 32'd0));
    repeat (3) @(negedge clk);

    // Four more transfers carry the 4-bit counter past its wrap (19 transfers in total)
    for (int i = 0; i < 4; i++)
      send(mk(OPIMM, 3'd0, 1'b0, 5'(i), 5'd0, 5'd0, 32'(i * 100 - 150)));
    repeat (2) @(negedge clk);
    check("wrap_count", out_count, 3);

    // Reset with two words buffered
    out_ready = 1'b0;
    send(mk(LUI, 3'd0, 1'b0, 5'd9, 5'd0, 5'd0, 32'hABCD_E000));
    send(mk(OP, 3'd0, 1'b0, 5'd9, 5'd9, 5'd9, 32'd0));
    check("pre_reset_in_ready", in_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_reset_out_valid", out_valid, 1'b0);
    check("mid_reset_out_count", out_count, 0);
    check("mid_reset_in_ready", in_ready, 1'b1);
    check("mid_reset_out_instr", out_instr, 0);
    out_ready = 1'b1;
    send_expect("after_reset", mk(OPIMM, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5), 32'h0050_0093, 1'b0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
